// File: rtl/iq_frame_packer.sv
// IQ sample FIFO with optional frame header insertion for the FX2LP sender.
// Define IQ_FRAME_HEADER_EN to enable header/seq framing; default is a plain FIFO.
module iq_frame_packer #(
   parameter int FIFO_DEPTH    = 32,
   parameter int PAYLOAD_WORDS = 16
) (
   input  logic        csi_clk,
   input  logic        rsi_reset,
   input  logic [31:0] asi_in0_data,
   input  logic        asi_in0_valid,
   output logic [31:0] aso_out0_data,
   output logic        aso_out0_valid,
   input  logic        aso_out0_ready,
   output logic        coe_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

   if (FIFO_DEPTH < 8 || FIFO_DEPTH > 256 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       PAYLOAD_WORDS < 1 || PAYLOAD_WORDS > FIFO_DEPTH) begin : g_bad_param
      $error("iq_frame_packer: illegal FIFO_DEPTH/PAYLOAD_WORDS");
   end

   logic [31:0] r_mem [FIFO_DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic [AW:0] w_occ;
   logic [31:0] w_head;
   logic        w_full;
   logic        w_push;
   logic        w_pop;
   logic        w_drop;
   logic        w_xfer;
   logic        r_ovf;

   // Pointers are one bit wider than the index so full and empty differ.
   assign w_occ  = r_wptr - r_rptr;
   assign w_full = (w_occ == DEPTH_L);
   assign w_head = r_mem[r_rptr[AW-1:0]];
   assign w_xfer = aso_out0_valid & aso_out0_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
   assign w_push = asi_in0_valid & (~w_full | w_pop);
   assign w_drop = asi_in0_valid & w_full & ~w_pop;

   assign coe_overflow = r_ovf;

   // Sample storage; no reset needed since occupancy guards every read.
   always_ff @(posedge csi_clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= asi_in0_data;
      end
   end

   // Read/write pointers, wrapping naturally modulo the pointer width.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

`ifdef IQ_FRAME_HEADER_EN

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD
   } state_t;

   localparam logic [AW:0] PW_L   = (AW+1)'(PAYLOAD_WORDS);
   localparam logic [AW:0] LAST_L = (AW+1)'(PAYLOAD_WORDS - 1);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_seq;
   logic [AW:0] r_cnt;
   logic        w_hdr_xfer;

   assign w_hdr_xfer = w_xfer & (r_state == S_HEADER);
   assign w_pop      = w_xfer & (r_state == S_PAYLOAD);

   // State register.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) r_state <= S_IDLE;
      else           r_state <= w_next;
   end

   // Next state: start a frame only once a full payload is buffered.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_occ >= PW_L) w_next = S_HEADER;
         end
         S_HEADER: begin
            if (w_xfer) w_next = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            if (w_xfer && r_cnt == LAST_L) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode: header word, show-ahead FIFO head, or idle zero.
   always_comb begin
      aso_out0_valid = 1'b0;
      aso_out0_data  = '0;
      unique case (r_state)
         S_HEADER: begin
            aso_out0_valid = 1'b1;
            aso_out0_data  = {8'hA5, r_ovf, 7'b0, r_seq};
         end
         S_PAYLOAD: begin
            aso_out0_valid = 1'b1;
            aso_out0_data  = w_head;
         end
         default: begin
            aso_out0_valid = 1'b0;
            aso_out0_data  = '0;
         end
      endcase
   end

   // Frame sequence number and payload word counter.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         r_seq <= '0;
         r_cnt <= '0;
      end else if (w_hdr_xfer) begin
         r_seq <= r_seq + 16'd1;
         r_cnt <= '0;
      end else if (w_pop) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Sticky drop flag, cleared when a header reports it downstream.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) r_ovf <= 1'b0;
      else           r_ovf <= w_drop | (r_ovf & ~w_hdr_xfer);
   end

`else

   logic w_empty;

   assign w_empty = (w_occ == '0);
   assign w_pop   = w_xfer;

   // Plain FIFO output: head word whenever anything is buffered.
   always_comb begin
      aso_out0_valid = ~w_empty;
      aso_out0_data  = w_empty ? 32'd0 : w_head;
   end

   // Sticky drop flag, cleared only by reset.
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) r_ovf <= 1'b0;
      else           r_ovf <= r_ovf | w_drop;
   end

`endif

endmodule

// File: tb/tb_iq_frame_packer.sv
// Directed bench for iq_frame_packer; checks the plain FIFO build by default
// and the framed build when IQ_FRAME_HEADER_EN is defined.
module tb_iq_frame_packer;

   logic        csi_clk;
   logic        rsi_reset;
   logic [31:0] asi_in0_data;
   logic        asi_in0_valid;
   logic [31:0] aso_out0_data;
   logic        aso_out0_valid;
   logic        aso_out0_ready;
   logic        coe_overflow;

   int n_cmp;
   int n_bad;
   int next_sample;
   logic [31:0] q_out[$];
   logic [31:0] exp_q[$];

   iq_frame_packer #(
      .FIFO_DEPTH    (32),
      .PAYLOAD_WORDS (16)
   ) dut (
      .csi_clk        (csi_clk),
      .rsi_reset      (rsi_reset),
      .asi_in0_data   (asi_in0_data),
      .asi_in0_valid  (asi_in0_valid),
      .aso_out0_data  (aso_out0_data),
      .aso_out0_valid (aso_out0_valid),
      .aso_out0_ready (aso_out0_ready),
      .coe_overflow   (coe_overflow)
   );

   initial csi_clk = 1'b0;
   always #5 csi_clk = ~csi_clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Drive inputs on the falling edge; outputs are then sampled mid-cycle.
   task automatic drive(input logic v, input logic [31:0] d, input logic r);
      @(negedge csi_clk);
      asi_in0_valid  = v;
      asi_in0_data   = d;
      aso_out0_ready = r;
      #1;
   endtask

   task automatic do_reset;
      @(negedge csi_clk);
      rsi_reset      = 1'b1;
      asi_in0_valid  = 1'b0;
      asi_in0_data   = '0;
      aso_out0_ready = 1'b0;
      @(negedge csi_clk);
      rsi_reset   = 1'b0;
      next_sample = 1;
      q_out.delete();
   endtask

   // Fixed-length run: ready every rp cycles (0 = never), a new sample
   // every vp cycles (0 = never) up to value lim; transfers go to q_out.
   task automatic run(input int ncyc, input int rp, input int vp,
                      input int lim);
      for (int c = 0; c < ncyc; c++) begin
         logic v;
         logic r;
         r = (rp > 0) && ((c % rp) == 0);
         v = (vp > 0) && ((c % vp) == 0) && (next_sample <= lim);
         drive(v, 32'(next_sample), r);
         if (v) next_sample++;
         if (aso_out0_valid && r) q_out.push_back(aso_out0_data);
      end
   endtask

   task automatic cmp_q(input string nm);
      int n;
      chk({nm, " count"}, 32'(q_out.size()), 32'(exp_q.size()));
      n = (q_out.size() < exp_q.size()) ? q_out.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s word%0d", nm, k), q_out[k], exp_q[k]);
      end
   endtask

`ifndef IQ_FRAME_HEADER_EN
   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        ev;
      logic [31:0] ed;
      logic        eo;
   } vec_t;

   vec_t tbl[12];
`endif

   initial begin
      n_cmp          = 0;
      n_bad          = 0;
      next_sample    = 1;
      rsi_reset      = 1'b1;
      asi_in0_valid  = 1'b0;
      asi_in0_data   = '0;
      aso_out0_ready = 1'b0;

      do_reset();
      #1;
      chk("reset valid", 32'(aso_out0_valid), 32'd0);
      chk("reset data", aso_out0_data, 32'd0);
      chk("reset ovf", 32'(coe_overflow), 32'd0);

`ifndef IQ_FRAME_HEADER_EN
      // Expected outputs reflect the state before this cycle's edge.
      tbl[0]  = '{1'b1, 32'hAAAA5555, 1'b0, 1'b0, 32'h00000000, 1'b0};
      tbl[1]  = '{1'b1, 32'h12345678, 1'b1, 1'b1, 32'hAAAA5555, 1'b0};
      tbl[2]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 32'h12345678, 1'b0};
      tbl[3]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 32'h12345678, 1'b0};
      tbl[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h12345678, 1'b0};
      tbl[5]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b0};
      tbl[6]  = '{1'b1, 32'h11111111, 1'b1, 1'b0, 32'h00000000, 1'b0};
      tbl[7]  = '{1'b1, 32'h22222222, 1'b0, 1'b1, 32'h11111111, 1'b0};
      tbl[8]  = '{1'b1, 32'h33333333, 1'b1, 1'b1, 32'h11111111, 1'b0};
      tbl[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h22222222, 1'b0};
      tbl[10] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h33333333, 1'b0};
      tbl[11] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0};

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].r);
         chk($sformatf("vec%0d valid", i), 32'(aso_out0_valid),
             32'(tbl[i].ev));
         chk($sformatf("vec%0d data", i), aso_out0_data, tbl[i].ed);
         chk($sformatf("vec%0d ovf", i), 32'(coe_overflow),
             32'(tbl[i].eo));
      end

      // Fill to full, then push and pop together while full.
      do_reset();
      run(32, 0, 1, 32);
      drive(1'b0, 32'd0, 1'b0);
      chk("full ovf", 32'(coe_overflow), 32'd0);
      chk("full head", aso_out0_data, 32'd1);
      drive(1'b1, 32'd33, 1'b1);
      drive(1'b0, 32'd0, 1'b0);
      chk("full push+pop ovf", 32'(coe_overflow), 32'd0);
      chk("full push+pop head", aso_out0_data, 32'd2);
      next_sample = 34;

      // Pushes into a full FIFO are dropped and flag overflow at once.
      run(1, 0, 1, 41);
      drive(1'b0, 32'd0, 1'b0);
      chk("ovf set", 32'(coe_overflow), 32'd1);
      run(7, 0, 1, 41);
      q_out.delete();
      run(40, 1, 0, 0);
      exp_q.delete();
      for (int k = 2; k <= 33; k++) exp_q.push_back(32'(k));
      cmp_q("drain");
      drive(1'b0, 32'd0, 1'b0);
      chk("drained valid", 32'(aso_out0_valid), 32'd0);
      chk("ovf sticky", 32'(coe_overflow), 32'd1);

      // Asynchronous reset mid-cycle, then a sample in the release cycle.
      run(3, 0, 1, 44);
      drive(1'b0, 32'd0, 1'b0);
      chk("pre-reset head", aso_out0_data, 32'd42);
      #2;
      rsi_reset = 1'b1;
      #1;
      chk("async rst valid", 32'(aso_out0_valid), 32'd0);
      chk("async rst data", aso_out0_data, 32'd0);
      chk("async rst ovf", 32'(coe_overflow), 32'd0);
      @(negedge csi_clk);
      rsi_reset      = 1'b0;
      asi_in0_valid  = 1'b1;
      asi_in0_data   = 32'hCAFEF00D;
      aso_out0_ready = 1'b0;
      drive(1'b0, 32'd0, 1'b0);
      chk("release sample valid", 32'(aso_out0_valid), 32'd1);
      chk("release sample data", aso_out0_data, 32'hCAFEF00D);
      drive(1'b0, 32'd0, 1'b1);
      drive(1'b0, 32'd0, 1'b0);
      chk("post-reset empty", 32'(aso_out0_valid), 32'd0);
`else
      // One frame with ready held high.
      run(16, 1, 1, 16);
      run(25, 1, 0, 0);
      exp_q.delete();
      exp_q.push_back(32'hA5000000);
      for (int k = 1; k <= 16; k++) exp_q.push_back(32'(k));
      cmp_q("frame0");
      chk("frame0 idle", 32'(aso_out0_valid), 32'd0);

      // Three frames with a slow sink and a slower source.
      do_reset();
      run(400, 5, 6, 48);
      exp_q.delete();
      for (int f = 0; f < 3; f++) begin
         exp_q.push_back(32'hA5000000 | 32'(f));
         for (int k = 1; k <= 16; k++) exp_q.push_back(32'(16 * f + k));
      end
      cmp_q("slow");
      chk("slow ovf", 32'(coe_overflow), 32'd0);

      // Overflow reported in the first header, cleared afterwards.
      do_reset();
      run(40, 0, 1, 40);
      drive(1'b0, 32'd0, 1'b0);
      chk("hdr ovf set", 32'(coe_overflow), 32'd1);
      q_out.delete();
      run(40, 1, 0, 0);
      exp_q.delete();
      exp_q.push_back(32'hA5800000);
      for (int k = 1; k <= 16; k++) exp_q.push_back(32'(k));
      exp_q.push_back(32'hA5000001);
      for (int k = 17; k <= 32; k++) exp_q.push_back(32'(k));
      cmp_q("ovf frames");
      chk("hdr ovf cleared", 32'(coe_overflow), 32'd0);

      // Reset after the header and five payload words.
      do_reset();
      run(16, 0, 1, 16);
      run(7, 1, 0, 0);
      exp_q.delete();
      exp_q.push_back(32'hA5000000);
      for (int k = 1; k <= 5; k++) exp_q.push_back(32'(k));
      cmp_q("partial");
      drive(1'b0, 32'd0, 1'b0);
      chk("partial head", aso_out0_data, 32'd6);
      #2;
      rsi_reset = 1'b1;
      #1;
      chk("mid-frame rst valid", 32'(aso_out0_valid), 32'd0);
      chk("mid-frame rst data", aso_out0_data, 32'd0);
      @(negedge csi_clk);
      rsi_reset = 1'b0;
      q_out.delete();
      run(16, 0, 1, 32);
      run(20, 1, 0, 0);
      exp_q.delete();
      exp_q.push_back(32'hA5000000);
      for (int k = 17; k <= 32; k++) exp_q.push_back(32'(k));
      cmp_q("after rst");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
